// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Reads the architectural PC from the
//            register file, issues single-word reads to instruction memory,
//            and buffers fetched words with their addresses in a small
//            circular prefetch queue for the decoder. Advances the PC through
//            the register file's increment strobe and discards in-flight and
//            queued words on a control-flow change (flush).
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            pcin                - current PC from the register file
//            pcincr              - PC increment strobe to the register file
//            flush               - control-flow change pulse (PC write cycle)
//            halt                - blocks new memory requests
//            mem_addr/mem_req    - memory read request (held until ack)
//            mem_ack/mem_rdata   - memory acknowledge and read data
//            instr/instr_pc      - head-of-queue word and its address
//            instr_valid         - queue not empty
//            instr_ready         - decoder consumes the head entry
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcin,
  output logic        pcincr,
  input  logic        flush,
  input  logic        halt,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_PC = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [PTRW:0]   c_depth   = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   c_cnt_one = 1;
  localparam logic [PTRW-1:0] c_ptr_one = 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pcincr;
  logic          w_pcincr_nxt;
  logic          w_req_nxt;
  logic [31:0]   w_addr_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_has_room;

  logic [31:0]   r_qdata [DEPTH];
  logic [31:0]   r_qpc   [DEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  logic [PTRW:0]   r_count;

  // The slot for the one outstanding request is reserved here, so a push
  // can never find the queue full.
  assign w_has_room  = (r_count < c_depth);
  assign instr_valid = (r_count != '0);
  assign instr       = r_qdata[r_rptr];
  assign instr_pc    = r_qpc[r_rptr];
  assign w_pop       = instr_valid && instr_ready;

  // The register file lets an increment override a same-cycle PC write, so
  // the strobe must be suppressed whenever a branch target is being written.
  assign pcincr = r_pcincr & ~flush;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      r_pcincr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      mem_req  <= w_req_nxt;
      mem_addr <= w_addr_nxt;
      r_pcincr <= w_pcincr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = mem_req;
    w_addr_nxt   = mem_addr;
    w_pcincr_nxt = r_pcincr;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!halt && !flush && w_has_room) begin
          w_addr_nxt  = pcin;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          w_req_nxt = 1'b0;
          if (!flush) begin
            w_push       = 1'b1;
            w_pcincr_nxt = 1'b1;
            w_state_nxt  = WAIT_PC;
          end else begin
            w_state_nxt  = IDLE;
          end
        end else if (flush) begin
          // The memory still owes us an ack; wait for it and drop the data.
          w_state_nxt = DISCARD;
        end
      end
      WAIT_PC: begin
        // One cycle so the register file has incremented before the next
        // IDLE cycle samples pcin.
        w_pcincr_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
      DISCARD: begin
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ prefetch queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_qdata[i] <= '0;
        r_qpc[i]   <= '0;
      end
    end else if (flush) begin
      // A flush cancels any push or pop in the same cycle.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_qdata[r_wptr] <= mem_rdata;
        r_qpc[r_wptr]   <= mem_addr;
        r_wptr          <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Models the register file PC,
//            an instruction memory with fixed or random wait states, and a
//            transaction-level queue scoreboard of expected decoder output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcin;
  logic        pcincr;
  logic        flush;
  logic        halt;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcin       (pcin),
    .pcincr     (pcincr),
    .flush      (flush),
    .halt       (halt),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];      // words the decoder should see, in order
  logic [31:0] rf_pc;      // register file PC
  logic [31:0] target;     // branch target written with flush
  bit          live;       // outstanding request will be delivered
  bit          incr_due;   // an accepted word owes one pcincr pulse
  bit          started;    // a new request began at the last edge
  bit          rand_ack;
  int          wcnt;
  int          wait_cfg;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    mq.delete();
    rf_pc    = '0;
    live     = 0;
    incr_due = 0;
    wcnt     = 0;
    started  = 0;
  endtask

  // One clock cycle: drive memory/RF inputs, check pre-edge outputs against
  // the scoreboard, advance past the edge, then update the model.
  task automatic tick();
    logic        p_req, p_ack, p_flush, p_ready, p_halt, p_incr;
    logic [31:0] p_addr, p_pc, p_tgt;
    int          p_qsize;
    bit          accepted;
    started = 0;
    pcin    = rf_pc;
    if (rand_ack) mem_ack = mem_req && ($urandom_range(0, 2) == 0);
    else          mem_ack = mem_req && (wcnt >= wait_cfg);
    mem_rdata = memf(mem_addr);
    #1;
    chk("pcincr", {31'd0, pcincr}, {31'd0, incr_due && !flush});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instr", instr, mq[0].data);
    end
    chk("count", {29'd0, dut.r_count}, mq.size());
    p_req = mem_req;  p_ack = mem_ack;  p_flush = flush;  p_ready = instr_ready;
    p_halt = halt;    p_incr = pcincr;  p_addr = mem_addr; p_pc = pcin;
    p_tgt = target;   p_qsize = mq.size();
    @(posedge clk);
    #1;
    accepted = p_req && p_ack && live && !p_flush;
    if (p_incr)       rf_pc = rf_pc + 32'd1;
    else if (p_flush) rf_pc = p_tgt;
    if (p_flush) mq.delete();
    else begin
      if (p_ready && mq.size() != 0) void'(mq.pop_front());
      if (accepted) mq.push_back('{pc: p_addr, data: memf(p_addr)});
    end
    incr_due = accepted;
    if (p_req && p_flush) live = 0;
    if (p_req) begin
      if (p_ack) chk("req_drop", {31'd0, mem_req}, 32'd0);
      else begin
        chk("req_hold", {31'd0, mem_req}, 32'd1);
        chk("addr_hold", mem_addr, p_addr);
      end
    end else if (mem_req) begin
      started = 1;
      live    = 1;
      chk("req_addr", mem_addr, p_pc);
      chk("req_allowed", {29'd0, p_halt, p_flush, p_qsize >= DEPTH}, 32'd0);
    end
    wcnt = (p_req && !p_ack) ? wcnt + 1 : 0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk("rst_req_async", {31'd0, mem_req}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic branch(input logic [31:0] t);
    flush  = 1'b1;
    target = t;
    tick();
    flush  = 1'b0;
  endtask

  task automatic wait_start(input string name, input logic [31:0] exp_addr);
    for (int n = 0; n < 20 && !started; n++) tick();
    chk({name, "_started"}, {31'd0, started}, 32'd1);
    chk({name, "_addr"}, mem_addr, exp_addr);
  endtask

  // ------------------------------------------------------ vector table
  typedef struct {
    logic        halt;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        incr;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Zero-wait run from PC 0: request, capture+pcincr, PC update, repeat.
    for (int i = 0; i < 12; i++) begin
      vecs[i].halt  = 1'b0;
      vecs[i].ready = 1'b1;
      vecs[i].addr  = i / 3;
      vecs[i].ipc   = i / 3;
      vecs[i].req   = (i % 3 == 0);
      vecs[i].incr  = (i % 3 == 1);
      vecs[i].valid = (i % 3 == 1);
    end

    rst = 1'b1; flush = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    pcin = '0; mem_ack = 1'b0; mem_rdata = '0; target = '0;
    rand_ack = 0; wait_cfg = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_pcincr", {31'd0, pcincr}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    rst = 1'b0;

    // Reset then run, table-driven.
    for (int i = 0; i < 12; i++) begin
      halt        = vecs[i].halt;
      instr_ready = vecs[i].ready;
      tick();
      chk($sformatf("run%0d_req", i), {31'd0, mem_req}, {31'd0, vecs[i].req});
      chk($sformatf("run%0d_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("run%0d_pcincr", i), {31'd0, pcincr}, {31'd0, vecs[i].incr});
      chk($sformatf("run%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].valid});
      if (vecs[i].valid) begin
        chk($sformatf("run%0d_ipc", i), instr_pc, vecs[i].ipc);
        chk($sformatf("run%0d_instr", i), instr, memf(vecs[i].ipc));
      end
    end

    // Wait states: ack after 3 wait cycles.
    wait_cfg = 3;
    wait_start("ws", 32'd4);
    begin
      logic [31:0] a0;
      a0 = mem_addr;
      for (int n = 0; n < 4; n++) begin
        if (n != 0) tick();
        chk("ws_req_stable", {31'd0, mem_req}, 32'd1);
        chk("ws_addr_stable", mem_addr, a0);
      end
      tick();
      chk("ws_req_done", {31'd0, mem_req}, 32'd0);
      chk("ws_pcincr", {31'd0, pcincr}, 32'd1);
      chk("ws_push_pc", instr_pc, a0);
      tick();
      chk("ws_pcincr_once", {31'd0, pcincr}, 32'd0);
    end

    // Queue fill from reset with the decoder stalled.
    do_reset();
    wait_cfg    = 0;
    instr_ready = 1'b0;
    for (int n = 0; n < 40 && mq.size() < DEPTH; n++) tick();
    chk("fill_size", mq.size(), DEPTH);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("fill_noreq", {31'd0, mem_req}, 32'd0);
    end
    chk("fill_head_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_start("fill_next", 32'd4);

    // Flush while the request to 4 waits for its ack.
    wait_cfg = 3;
    branch(32'h100);
    chk("disc_req_held", {31'd0, mem_req}, 32'd1);
    chk("disc_addr_held", mem_addr, 32'd4);
    chk("disc_queue_empty", {31'd0, instr_valid}, 32'd0);
    for (int n = 0; n < 10 && mem_req; n++) begin
      tick();
      chk("disc_no_pcincr", {31'd0, pcincr}, 32'd0);
    end
    chk("disc_req_dropped", {31'd0, mem_req}, 32'd0);
    chk("disc_no_push", {31'd0, instr_valid}, 32'd0);
    wait_start("disc_next", 32'h100);

    // Flush coinciding with ack.
    wait_cfg = 0;
    branch(32'h200);
    chk("fack_req", {31'd0, mem_req}, 32'd0);
    chk("fack_pcincr", {31'd0, pcincr}, 32'd0);
    chk("fack_no_word", {31'd0, instr_valid}, 32'd0);
    wait_start("fack_next", 32'h200);

    // Flush during WAIT_PC.
    tick();
    chk("fwait_pcincr_reg", {31'd0, pcincr}, 32'd1);
    flush  = 1'b1;
    target = 32'h300;
    #1;
    chk("fwait_pcincr_gated", {31'd0, pcincr}, 32'd0);
    tick();
    flush = 1'b0;
    chk("fwait_no_word", {31'd0, instr_valid}, 32'd0);
    wait_start("fwait_next", 32'h300);

    // Simultaneous push and pop across pointer wrap.
    for (int n = 0; n < 30 && mq.size() < 2; n++) tick();
    chk("pp_prefill", mq.size(), 2);
    for (int n = 0; n < 30; n++) begin
      instr_ready = mem_req;
      tick();
      chk("pp_count", {29'd0, dut.r_count}, 32'd2);
    end
    instr_ready = 1'b1;
    repeat (4) tick();

    // Randomized traffic against the scoreboard.
    rand_ack = 1;
    for (int n = 0; n < 900; n++) begin
      instr_ready = 1'($urandom_range(0, 1));
      halt        = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      target      = $urandom;
      tick();
      flush = 1'b0;
    end
    halt = 1'b0;

    // Asynchronous reset in the middle of a request.
    rand_ack = 0;
    wait_cfg = 5;
    for (int n = 0; n < 30 && !mem_req; n++) tick();
    chk("arst_pre_req", {31'd0, mem_req}, 32'd1);
    do_reset();
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the register file. It reads the architectural PC from the register file, issues single-word reads to instruction memory, and buffers fetched words with their addresses in a small prefetch queue for the decoder. It advances the PC through the register file's increment strobe and discards in-flight and queued words when the core signals a control-flow change.

## Interface

Parameters:

- DEPTH, 4: prefetch queue entries, power of two, at least 2.
- PTRW, 2: queue pointer width, log2(DEPTH).

Ports:

- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcin  in  32  current PC from the register file's PC output.
- pcincr  out  1  PC increment strobe to the register file.
- flush  in  1  one-cycle pulse, asserted in the same cycle the PC is written by a branch or jump.
- halt  in  1  when high, no new memory request is started.
- mem_addr  out  32  word address of the current request.
- mem_req  out  1  read request; held until acknowledged.
- mem_ack  in  1  read acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read data.
- instr  out  32  head-of-queue instruction word.
- instr_pc  out  32  address that instr was fetched from.
- instr_valid  out  1  queue not empty.
- instr_ready  in  1  decoder consumes the head entry when it is high together with instr_valid.

## Operation

- Reset forces:
  - mem_req = 0, mem_addr = 0, pcincr = 0.
  - instr_valid = 0, instr = 0, instr_pc = 0.
  - Queue count and pointers = 0; state = IDLE.
- The FSM has four states: IDLE, REQ, WAIT_PC and DISCARD.
- **IDLE:**
  - If !halt && !flush && count < DEPTH, latch mem_addr <= pcin, set mem_req <= 1 and go to REQ.
  - Otherwise stay in IDLE.
  - At most one request is outstanding. Its queue slot is reserved by the count < DEPTH test.
- **REQ:**
  - mem_req stays high and mem_addr stays stable until mem_ack is sampled.
  - On mem_ack && !flush: mem_req <= 0, push {mem_rdata, mem_addr}, set the internal pcincr register, go to WAIT_PC.
  - On mem_ack && flush: mem_req <= 0, discard the data, no pcincr, go to IDLE.
  - On !mem_ack && flush: go to DISCARD.
- **WAIT_PC:**
  - Lasts one cycle, so the register file increments the PC at the end of it.
  - Clear the pcincr register and go to IDLE.
- **DISCARD:**
  - Keep mem_req high until mem_ack.
  - On ack, drop mem_req, drop the data, make no push and no pcincr, and go to IDLE.
  - flush in this state has no further effect.
- **pcincr output** = internal pcincr register AND !flush.
  - This gating is mandatory. In the register file an increment overrides a same-cycle PC write, so the branch target would otherwise be lost.
- **Queue:**
  - Circular buffer with PTRW-bit wrapping pointers and a count from 0 to DEPTH.
  - instr and instr_pc are driven from the head entry; instr_valid = (count != 0).
  - A pop happens on instr_valid && instr_ready.
  - A simultaneous push and pop leaves count unchanged; both pointers advance, and each wraps from DEPTH-1 to 0.
  - A pop while empty is ignored.
  - A push while full cannot occur because the slot was reserved.
- **Flush:**
  - At the flush edge, count and both pointers are cleared.
  - Any push or pop in that same cycle is cancelled.
  - instr_valid is low in the following cycle.
  - The PC value written by the branch is picked up by the next IDLE request.
- **Halt:**
  - Only blocks new requests.
  - An outstanding request completes normally, including its push and pcincr.
  - Queue draining is unaffected.
- PC arithmetic is the register file's +1, so addresses are word addresses. The block computes no addresses itself.

## Timing

- All outputs except pcincr are registered. pcincr is the registered pulse gated combinationally by flush.
- mem_ack may be high in the first cycle that mem_req is high.
- Zero-wait fetch sequence:
  - Edge E0: request starts.
  - Edge E1: data is captured and pcincr rises.
  - Edge E2: the register file updates the PC; the FSM returns to IDLE.
  - Edge E3: the next request starts.
- Throughput is therefore one word per 3 cycles with zero-wait memory, plus N cycles for N memory wait cycles.
- Fetch to decoder latency: a word captured at edge E1 has instr_valid high from E1 onward.
- pcincr is high for exactly one cycle per accepted word, and never in a cycle with flush high.
- Asserting rst mid-request drops mem_req immediately, asynchronously. The memory side must tolerate an abandoned request.

## Test plan

- **Reset then run:** pcin follows the register file from 0x0000_0000, memory has zero wait, instr_ready = 1. Required: mem_addr sequence 0,1,2,3 with requests at edges E0, E3, E6, E9. Each instr_pc matches its word. Exactly one pcincr pulse per word.
- **Queue fill with DEPTH=4:** instr_ready = 0. Required: 4 words queued, count = 4, and mem_req stays low afterwards. Raising instr_ready for 1 cycle pops the word at instr_pc 0x0 and a new request to address 4 follows.
- **Wait states:** mem_ack delayed 3 cycles. Required: mem_req and mem_addr stable for 4 cycles, then one push and one pcincr.
- **Flush during REQ without ack:** flush pulses while pcin becomes 0x100. Required: DISCARD state, req held to ack, data dropped, no pcincr, queue empty, next mem_addr = 0x100.
- **Flush coinciding with ack, and flush during WAIT_PC:** Required in both cases: pcincr stays 0 in the flush cycle, the word is not delivered, and the next fetch is from the branch target.
- **Simultaneous push and pop with wrap-around:** drive the pointers through the DEPTH-1 to 0 wrap. Required: count is unchanged on a simultaneous push and pop, and the FIFO ordering of instr_pc is preserved.
